// File: rtl/ping_pong_counter_multi.sv
// Bounded up/down sweep counter (ping-pong, wrap-up, wrap-down) with registered bounce pulse
// and saturating bounce counter; all outputs registered, one-cycle update, no backpressure.
module ping_pong_counter_multi #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              flip,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr_cnt,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  min,
  input  logic [WIDTH-1:0]  max,
  input  logic [STEP_W-1:0] step,
  output logic              direction,
  output logic [WIDTH-1:0]  out,
  output logic              bounce,
  output logic [CNT_W-1:0]  bounce_cnt
);

  // Wide enough for both operands plus a guard bit, so comparisons never wrap.
  localparam int AW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_out;
  logic             r_dir;
  logic             r_bounce;
  logic [CNT_W-1:0] r_cnt;

  logic [AW-1:0]    w_min, w_max, w_out, w_step, w_span, w_s, w_d, w_e;
  logic [WIDTH-1:0] w_sn, w_dn, w_en, w_clamp;
  logic             w_range_ok, w_hold, w_ed;
  logic [WIDTH-1:0] w_nxt_out;
  logic             w_nxt_dir, w_nxt_bounce;

  assign w_min  = {{(AW-WIDTH){1'b0}}, min};
  assign w_max  = {{(AW-WIDTH){1'b0}}, max};
  assign w_out  = {{(AW-WIDTH){1'b0}}, r_out};
  assign w_step = {{(AW-STEP_W){1'b0}}, step};
  assign w_span = w_max - w_min;
  assign w_s    = (w_step < w_span) ? w_step : w_span;
  assign w_d    = w_max - w_out;
  assign w_e    = w_out - w_min;

  // s, d and e are all bounded by max-min in the advance case, so WIDTH bits suffice.
  assign w_sn = w_s[WIDTH-1:0];
  assign w_dn = w_d[WIDTH-1:0];
  assign w_en = w_e[WIDTH-1:0];

  assign w_range_ok = (max > min);
  assign w_hold     = !enable || !w_range_ok || (r_out < min) || (r_out > max) || (step == '0);
  assign w_clamp    = (load_val < min) ? min : ((load_val > max) ? max : load_val);
  assign w_ed       = r_dir ^ flip;

  always_comb begin
    w_nxt_out    = r_out;
    w_nxt_dir    = r_dir;
    w_nxt_bounce = 1'b0;
    if (load && w_range_ok) begin
      w_nxt_out = w_clamp;
    end else if (!w_hold) begin
      case (mode)
        2'd1: begin
          w_nxt_dir = 1'b0;
          if (w_s <= w_d) begin
            w_nxt_out = r_out + w_sn;
          end else begin
            w_nxt_out    = min + (w_sn - w_dn - ONE);
            w_nxt_bounce = 1'b1;
          end
        end
        2'd2: begin
          w_nxt_dir = 1'b1;
          if (w_s <= w_e) begin
            w_nxt_out = r_out - w_sn;
          end else begin
            w_nxt_out    = max - (w_sn - w_en - ONE);
            w_nxt_bounce = 1'b1;
          end
        end
        default: begin
          if (!w_ed) begin
            if (w_s <= w_d) begin
              w_nxt_out = r_out + w_sn;
              w_nxt_dir = 1'b0;
            end else begin
              w_nxt_out    = max - (w_sn - w_dn);
              w_nxt_dir    = 1'b1;
              w_nxt_bounce = 1'b1;
            end
          end else begin
            if (w_s <= w_e) begin
              w_nxt_out = r_out - w_sn;
              w_nxt_dir = 1'b1;
            end else begin
              w_nxt_out    = min + (w_sn - w_en);
              w_nxt_dir    = 1'b0;
              w_nxt_bounce = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out    <= min;
      r_dir    <= 1'b0;
      r_bounce <= 1'b0;
    end else begin
      r_out    <= w_nxt_out;
      r_dir    <= w_nxt_dir;
      r_bounce <= w_nxt_bounce;
    end
  end

  // Clear wins over a coincident bounce; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_cnt) begin
      r_cnt <= '0;
    end else if (w_nxt_bounce && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out        = r_out;
  assign direction  = r_dir;
  assign bounce     = r_bounce;
  assign bounce_cnt = r_cnt;

endmodule

// File: tb/tb_ping_pong_counter_multi.sv
// Directed self-checking bench for ping_pong_counter_multi (default parameters).
module tb_ping_pong_counter_multi;

  logic       clk = 1'b0;
  logic       rst_n, enable, flip, load, clr_cnt;
  logic [7:0] load_val, min, max;
  logic [1:0] mode;
  logic [3:0] step;
  logic       direction, bounce;
  logic [7:0] out, bounce_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ping_pong_counter_multi dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flip(flip), .load(load),
    .load_val(load_val), .clr_cnt(clr_cnt), .mode(mode), .min(min), .max(max),
    .step(step), .direction(direction), .out(out), .bounce(bounce),
    .bounce_cnt(bounce_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic adv_chk(input string tag, input int eo, input int edir, input int eb);
    tick();
    check({tag, ".out"}, 32'(out), 32'(eo));
    check({tag, ".dir"}, 32'(direction), 32'(edir));
    check({tag, ".bnc"}, 32'(bounce), 32'(eb));
  endtask

  initial begin
    int t1_o[7] = '{3, 4, 5, 4, 3, 2, 3};
    int t1_d[7] = '{0, 0, 0, 1, 1, 1, 0};
    int t1_b[7] = '{0, 0, 0, 1, 0, 0, 1};
    int t2_o[8] = '{3, 6, 9, 8, 5, 2, 1, 4};
    int t2_d[8] = '{0, 0, 0, 1, 1, 1, 0, 0};
    int t2_b[8] = '{0, 0, 0, 1, 0, 0, 1, 0};

    rst_n = 1'b0; enable = 1'b0; flip = 1'b0; load = 1'b0; clr_cnt = 1'b0;
    load_val = 8'd0; mode = 2'd0; min = 8'd2; max = 8'd5; step = 4'd1;
    #2;

    // Reset state
    do_reset();
    check("rst.out", 32'(out), 32'd2);
    check("rst.dir", 32'(direction), 32'd0);
    check("rst.bnc", 32'(bounce), 32'd0);
    check("rst.cnt", 32'(bounce_cnt), 32'd0);

    // 1: ping-pong step 1 over [2,5]
    enable = 1'b1;
    for (int i = 0; i < 7; i++) adv_chk($sformatf("t1[%0d]", i), t1_o[i], t1_d[i], t1_b[i]);
    check("t1.cnt", 32'(bounce_cnt), 32'd2);

    // 2: step 3 over [0,10], then step clamped to the span
    min = 8'd0; max = 8'd10; step = 4'd3;
    do_reset();
    check("t2.start", 32'(out), 32'd0);
    for (int i = 0; i < 8; i++) adv_chk($sformatf("t2[%0d]", i), t2_o[i], t2_d[i], t2_b[i]);
    step = 4'd15;
    do_reset();
    adv_chk("t2c[0]", 10, 0, 0);
    adv_chk("t2c[1]", 0, 1, 1);

    // 3: wrap-up then wrap-down over [1,6] step 2
    mode = 2'd1; min = 8'd1; max = 8'd6; step = 4'd2;
    do_reset();
    adv_chk("t3u[0]", 3, 0, 0);
    adv_chk("t3u[1]", 5, 0, 0);
    adv_chk("t3u[2]", 1, 0, 1);
    adv_chk("t3u[3]", 3, 0, 0);
    adv_chk("t3u[4]", 5, 0, 0);
    adv_chk("t3u[5]", 1, 0, 1);
    mode = 2'd2; load = 1'b1; load_val = 8'd6;
    tick();
    load = 1'b0;
    check("t3d.load", 32'(out), 32'd6);
    adv_chk("t3d[0]", 4, 1, 0);
    adv_chk("t3d[1]", 2, 1, 0);
    adv_chk("t3d[2]", 6, 1, 1);

    // 4: flip over [3,7]
    mode = 2'd0; min = 8'd3; max = 8'd7; step = 4'd1;
    do_reset();
    flip = 1'b1;
    adv_chk("t4.flip_at_min_up", 4, 0, 1);
    adv_chk("t4.flip_down", 3, 1, 0);
    adv_chk("t4.flip_at_min_dn", 4, 0, 0);
    flip = 1'b0;

    // 5: empty range holds and ignores load; clamped load; load while disabled
    min = 8'd4; max = 8'd4;
    do_reset();
    load = 1'b1; load_val = 8'd9;
    adv_chk("t5.norange", 4, 0, 0);
    min = 8'd3; max = 8'd7; load_val = 8'd20;
    adv_chk("t5.load_hi", 7, 0, 0);
    load_val = 8'd1;
    adv_chk("t5.load_lo", 3, 0, 0);
    enable = 1'b0; load_val = 8'd5;
    adv_chk("t5.load_dis", 5, 0, 0);
    load = 1'b0;
    adv_chk("t5.hold_dis", 5, 0, 0);
    enable = 1'b1; min = 8'd6;
    adv_chk("t5.hold_oor", 5, 0, 0);

    // 6: mid-sweep reset beats load, then saturation and clear-vs-bounce
    min = 8'd2; max = 8'd5;
    do_reset();
    repeat (4) tick();
    check("t6.pre_bnc", 32'(bounce), 32'd1);
    load = 1'b1; load_val = 8'd4;
    do_reset();
    load = 1'b0;
    check("t6.rst.out", 32'(out), 32'd2);
    check("t6.rst.dir", 32'(direction), 32'd0);
    check("t6.rst.bnc", 32'(bounce), 32'd0);
    check("t6.rst.cnt", 32'(bounce_cnt), 32'd0);
    min = 8'd0; max = 8'd1;
    do_reset();
    repeat (300) tick();
    check("t6.sat", 32'(bounce_cnt), 32'd255);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("t6.clr.bnc", 32'(bounce), 32'd1);
    check("t6.clr.cnt", 32'(bounce_cnt), 32'd0);
    tick();
    check("t6.after_clr", 32'(bounce_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
